layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Top-level run controller for the CNN inference accelerator.
- On one `start` pulse, it sequences the stage engines in fixed order, one at a time, with a start/done handshake per stage.
- It guards each stage with a watchdog timeout, captures the final Q8.8 classifier output, and reports completion and errors to the host or testbench.
- It sits between the host interface and the per-layer engines (conv, pool, dense, activation).

Parameters:
- NUM_STAGES, 4, number of stage engines sequenced; stage indices run 0..NUM_STAGES-1 in ascending order; minimum 1.
- TIMEOUT, 100000, maximum cycles spent in WAIT per stage before a timeout error is declared.
- ACT_ENABLE, 1, when 1 a ReLU is applied to the captured result (negative becomes 0); when 0 the result is passed through.
- CNT_W, 32, width of the run cycle counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  run request; sampled only in IDLE.
- stage_start  output  NUM_STAGES  one-hot, one-cycle start pulse to the selected engine.
- stage_done  input  NUM_STAGES  per-engine done; level or pulse accepted.
- stage_result  input  16  signed Q8.8 output of the last stage; valid when stage_done[NUM_STAGES-1] is high.
- busy  output  1  high from start acceptance until completion or error.
- done_out  output  1  level; high after a run ends (success or timeout) until the next accepted start.
- final_out  output  16  signed Q8.8 registered result.
- timeout_err  output  1  level; set on watchdog expiry, cleared on the next accepted start.
- err_stage  output  $clog2(NUM_STAGES) or 1 bit minimum  index of the stage that timed out.
- cur_stage  output  $clog2(NUM_STAGES) or 1 bit minimum  index of the stage currently issued or awaited.
- run_cycles  output  CNT_W  cycles from start acceptance to run end; saturates at all-ones.

Behaviour:
- Reset values: stage_start=0, busy=0, done_out=0, final_out=0, timeout_err=0, err_stage=0, cur_stage=0, run_cycles=0. State is IDLE, watchdog is 0.
- Reset mid-run: everything returns to reset values immediately. No further stage_start pulses are issued.
- States: IDLE, ISSUE, WAIT, ERROR.
- IDLE:
  - If start=1 at edge 0: go to ISSUE, set busy=1, done_out=0, timeout_err=0, cur_stage=0, run_cycles=0.
  - If start=0: remain in IDLE.
- ISSUE (exactly one cycle):
  - stage_start[cur_stage]=1; all other bits 0.
  - Watchdog cleared to 0.
  - Next state is WAIT.
  - Stage 0 is therefore pulsed in the cycle after start acceptance.
- WAIT:
  - Only stage_done[cur_stage] is observed; all other done bits are ignored.
  - done for stage i < NUM_STAGES-1: cur_stage=i+1, next state ISSUE. There is one idle cycle between a done and the next stage_start.
  - done for the last stage: final_out is registered as ACT_ENABLE ? max(stage_result,0) : stage_result. On the same edge done_out=1, busy=0, next state IDLE.
  - No done: the watchdog increments. If the watchdog equals TIMEOUT-1 on this edge, go to ERROR.
  - done and watchdog expiry in the same cycle: done wins.
- ERROR (one cycle):
  - timeout_err=1, err_stage=cur_stage, done_out=1, busy=0, next state IDLE.
  - final_out keeps its previous value.
- stage_done is not observed during ISSUE. A done asserted in the same cycle as its own stage_start is lost, so engines need at least 1 cycle of latency.
- start received while busy, or during the ERROR cycle, is ignored (it is not queued).
- start received in IDLE while done_out=1 begins a new run; done_out clears on that edge.
- run_cycles:
  - Increments every cycle while busy=1, saturating at 2^CNT_W-1.
  - It is frozen and readable from run end until the next accepted start.
- busy and done_out are never high together.
- stage_start is never multi-hot and is never asserted outside ISSUE.

Test Plan:
- Reset with stage_done forced to all-ones, then start pulse -> all outputs 0 while in reset. After release, stage_start[0] pulses exactly one cycle after start; no other pulse until WAIT sees done[0].
- Nominal run, NUM_STAGES=3, each engine returns done 5 cycles after its start, stage_result=16'hFF80 (-0.5), ACT_ENABLE=0:
  - stage_start pulses 0,1,2 in order, 7 cycles apart.
  - done_out rises with final_out=16'hFF80 and busy falls.
  - run_cycles=20.
- Same run with ACT_ENABLE=1 -> final_out=0. Repeat with stage_result=16'h0180 -> final_out=16'h0180 (1.5).
- TIMEOUT=16, stage 1 never responds:
  - timeout_err=1, err_stage=1, done_out=1, final_out unchanged.
  - No stage_start[2] pulse.
  - The next start clears timeout_err.
- Corner cases:
  - done asserted on the exact expiry cycle -> no error.
  - start pulses during busy and stray stage_done on non-current stages -> ignored, sequence unchanged.
  - done coincident with stage_start -> no advance (watchdog expires).
- Reset asserted mid-WAIT of stage 2 -> immediate return to reset values. A fresh start restarts from stage 0.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: issues stage engines in order with a per-stage watchdog and captures the final Q8.8 result
module layer_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT = 100000,
  parameter bit ACT_ENABLE = 1,
  parameter int CNT_W = 32,
  localparam int SW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1,
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [NUM_STAGES-1:0]  stage_start,
  input  logic [NUM_STAGES-1:0]  stage_done,
  input  logic signed [15:0]     stage_result,
  output logic                   busy,
  output logic                   done_out,
  output logic signed [15:0]     final_out,
  output logic                   timeout_err,
  output logic [SW-1:0]          err_stage,
  output logic [SW-1:0]          cur_stage,
  output logic [CNT_W-1:0]       run_cycles
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERROR} state_t;
  state_t state;
  logic [WW-1:0] wd;
  logic hit, last, expired;
  logic [CNT_W-1:0] cnt_inc;
  assign hit = stage_done[cur_stage];
  assign last = cur_stage == SW'(NUM_STAGES - 1);
  assign expired = wd == WW'(TIMEOUT - 1);
  assign cnt_inc = &run_cycles ? run_cycles : run_cycles + CNT_W'(1);
  // stage_start is registered on entry to ISSUE so it is high exactly while in ISSUE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wd <= '0;
      stage_start <= '0;
      busy <= 1'b0;
      done_out <= 1'b0;
      final_out <= '0;
      timeout_err <= 1'b0;
      err_stage <= '0;
      cur_stage <= '0;
      run_cycles <= '0;
    end else begin
      stage_start <= '0;
      unique case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          stage_start <= NUM_STAGES'(1);
          busy <= 1'b1;
          done_out <= 1'b0;
          timeout_err <= 1'b0;
          cur_stage <= '0;
          run_cycles <= '0;
        end
        ISSUE: begin
          state <= WAIT;
          wd <= '0;
          run_cycles <= cnt_inc;
        end
        WAIT: begin
          if (!(hit && last)) run_cycles <= cnt_inc;
          if (hit && last) begin
            final_out <= (ACT_ENABLE && stage_result[15]) ? '0 : stage_result;
            done_out <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else if (hit) begin
            cur_stage <= cur_stage + 1'b1;
            stage_start <= NUM_STAGES'(1) << (cur_stage + 1'b1);
            state <= ISSUE;
          end else if (expired) begin
            state <= ERROR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ERROR: begin
          timeout_err <= 1'b1;
          err_stage <= cur_stage;
          done_out <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed checks of a 3-stage sequencer, raw (u0) and ReLU (u1) variants
module tb_layer_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0] stage_done = '0;
  logic [15:0] stage_result = '0;
  logic [2:0] ss_a, ss_b, seen;
  logic busy_a, busy_b, done_a, done_b, terr_a, terr_b;
  logic [15:0] fo_a, fo_b;
  logic [1:0] es_a, es_b, cs_a, cs_b;
  logic [31:0] rc_a, rc_b;
  int vec = 0, errs = 0, cyc = 0, t0 = 0;

  layer_sequencer #(.NUM_STAGES(3), .TIMEOUT(16), .ACT_ENABLE(1'b0), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .start(start), .stage_start(ss_a), .stage_done(stage_done),
    .stage_result(stage_result), .busy(busy_a), .done_out(done_a), .final_out(fo_a),
    .timeout_err(terr_a), .err_stage(es_a), .cur_stage(cs_a), .run_cycles(rc_a));

  layer_sequencer #(.NUM_STAGES(3), .TIMEOUT(16), .ACT_ENABLE(1'b1), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .start(start), .stage_start(ss_b), .stage_done(stage_done),
    .stage_result(stage_result), .busy(busy_b), .done_out(done_b), .final_out(fo_b),
    .timeout_err(terr_b), .err_stage(es_b), .cur_stage(cs_b), .run_cycles(rc_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vec++;
    assert (obs === want) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // engine answers 6 cycles after its ISSUE cycle; noise adds busy-time starts and stray dones
  task automatic serve(input int idx, input bit noise);
    logic [2:0] q;
    q = '0;
    for (int k = 1; k <= 6; k++) begin
      if (noise) begin
        start = k[0];
        stage_done = ~(3'b001 << idx);
      end
      step();
      q |= ss_a;
    end
    chk($sformatf("quiet_s%0d", idx), q, 0);
    start = 1'b0;
    stage_done = 3'b001 << idx;
    step();
    stage_done = '0;
  endtask

  initial begin
    stage_done = 3'b111;
    start = 1'b1;
    repeat (3) step();
    chk("rst_out", {ss_a, busy_a, done_a, fo_a, terr_a, es_a, cs_a}, 0);
    chk("rst_cnt", rc_a, 0);
    reset = 1'b0; start = 1'b0; stage_done = '0;
    step();

    stage_result = 16'hFF80;
    start = 1'b1; step(); start = 1'b0; t0 = cyc;
    chk("r1_s0", ss_a, 3'b001);
    chk("r1_busy", {busy_a, done_a}, 2'b10);
    serve(0, 1'b0);
    chk("r1_s1", {ss_a, cs_a, 8'(cyc - t0)}, {3'b010, 2'd1, 8'd7});
    serve(1, 1'b0);
    chk("r1_s2", {ss_a, cs_a, 8'(cyc - t0)}, {3'b100, 2'd2, 8'd14});
    serve(2, 1'b0);
    chk("r1_end", {busy_a, done_a, terr_a, ss_a}, 6'b010000);
    chk("r1_final_raw", fo_a, 16'hFF80);
    chk("r1_final_relu", fo_b, 16'h0000);
    chk("r1_cycles", rc_a, 20);
    chk("r1_b_ctrl", {busy_b, done_b, terr_b, ss_b, cs_b, es_b, rc_b},
        {1'b0, 1'b1, 1'b0, 3'b000, 2'd2, 2'd0, 32'd20});

    stage_result = 16'h0180;
    start = 1'b1; step(); start = 1'b0; t0 = cyc;
    chk("r2_clr", {busy_a, done_a, rc_a}, {2'b10, 32'd0});
    serve(0, 1'b1);
    chk("r2_s1", {ss_a, 8'(cyc - t0)}, {3'b010, 8'd7});
    serve(1, 1'b1);
    chk("r2_s2", {ss_a, 8'(cyc - t0)}, {3'b100, 8'd14});
    serve(2, 1'b1);
    chk("r2_final", {fo_a, fo_b}, {16'h0180, 16'h0180});
    chk("r2_cycles", {busy_a, done_a, rc_a}, {2'b01, 32'd20});

    start = 1'b1; step(); start = 1'b0;
    serve(0, 1'b0);
    seen = '0;
    repeat (16) begin step(); seen |= ss_a; end
    chk("r3_wait", {busy_a, terr_a, seen}, {2'b10, 3'b000});
    start = 1'b1; step();
    chk("r3_errcyc", {busy_a, done_a, terr_a}, 3'b100);
    step(); start = 1'b0;
    chk("r3_err", {terr_a, es_a, done_a, busy_a, ss_a}, {1'b1, 2'd1, 2'b10, 3'b000});
    chk("r3_keep", {fo_a, rc_a}, {16'h0180, 32'd24});
    step();
    chk("r3_noqueue", {busy_a, done_a, terr_a}, 3'b011);

    start = 1'b1; step(); start = 1'b0;
    chk("r4_clr", {terr_a, done_a, busy_a}, 3'b001);
    repeat (16) step();
    stage_done = 3'b001; step(); stage_done = '0;
    chk("r4_edge_done", {ss_a, terr_a, busy_a}, {3'b010, 2'b01});
    stage_done = 3'b010; step(); stage_done = '0;
    chk("r4_lost", {cs_a, ss_a}, {2'd1, 3'b000});
    seen = '0;
    repeat (17) begin step(); seen |= ss_a; end
    chk("r4_err", {terr_a, es_a, done_a, busy_a, seen}, {1'b1, 2'd1, 2'b10, 3'b000});
    chk("r4_cycles", rc_a, 34);

    start = 1'b1; step(); start = 1'b0;
    serve(0, 1'b0);
    serve(1, 1'b0);
    chk("r5_s2", ss_a, 3'b100);
    step(); step();
    reset = 1'b1; #1;
    chk("r5_rst", {ss_a, busy_a, done_a, fo_a, terr_a, es_a, cs_a, rc_a}, 0);
    step(); reset = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    chk("r5_restart", {ss_a, cs_a, busy_a}, {3'b001, 2'd0, 1'b1});
    serve(0, 1'b0);
    chk("r5_s1", {ss_a, cs_a}, {3'b010, 2'd1});
    reset = 1'b1; step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
